// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } ps2_state_t;

  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

  localparam int START_BITS  = 1;
  localparam int PARITY_BITS = 1;
  localparam int STOP_BITS   = 1;

  // Total bits on the wire for one frame.
  function automatic int frame_len(input int data_bits);
    return START_BITS + data_bits + PARITY_BITS + STOP_BITS;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser, glitch filter and falling-edge pulse for the raw PS/2 clock pin.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall_edge
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          cnt_q;
  logic                   filt_q;
  logic                   fall_q;
  logic                   sync_bit;
  logic                   flip;

  assign sync_bit  = sync_q[SYNC_STAGES-1];
  // The filtered level only moves once FILTER_LEN samples in a row disagree with it.
  assign flip      = (sync_bit != filt_q) && (cnt_q == FW'(FILTER_LEN - 1));
  assign fall_edge = fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fall_q <= flip & filt_q;
      if (sync_bit == filt_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q  <= '0;
        filt_q <= sync_bit;
      end else begin
        cnt_q <= cnt_q + FW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: one word per frame with parity/stop error flags.
// Optional partial-frame timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int ODD_PARITY     = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_c,
  input  logic                 ps2_d,
  input  logic                 tx_idle,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_timeout,
  output logic                 busy
);

  localparam int   CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic PAR_MODE = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || SYNC_STAGES < 2 || FILTER_LEN < 1 ||
        TIMEOUT_CYCLES < 2 || frame_len(DATA_BITS) > 12) begin : g_bad_cfg
      $error("ps2_rx_frame: illegal parameter combination");
    end
  endgenerate

  ps2_state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] d_sync_q;
  logic                   d_bit;
  logic                   fall_edge;
  logic                   edge_ok;
  logic                   to_take;
  logic [DATA_BITS-1:0]   shift_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   par_bit_q;
  logic                   par_err_c;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .rst       (rst),
    .din       (ps2_c),
    .fall_edge (fall_edge)
  );

  // The data line only needs synchronising; it is stable around the clock fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_sync_q <= '1;
    else      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ps2_d};
  end

  assign d_bit     = d_sync_q[SYNC_STAGES-1];
  assign edge_ok   = fall_edge & tx_idle;
  assign par_err_c = (^{shift_q, par_bit_q}) ^ PAR_MODE;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Abort (tx_idle low) beats a coincident edge; an edge beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (edge_ok && !d_bit) state_d = DATA;
      end
      DATA: begin
        if (!tx_idle)                                       state_d = IDLE;
        else if (fall_edge && cnt_q == CNT_W'(DATA_BITS-1)) state_d = PARITY;
        else if (to_take)                                   state_d = IDLE;
      end
      PARITY: begin
        if (!tx_idle)       state_d = IDLE;
        else if (fall_edge) state_d = STOP;
        else if (to_take)   state_d = IDLE;
      end
      STOP: begin
        if (!tx_idle)       state_d = IDLE;
        else if (fall_edge) state_d = DONE;
        else if (to_take)   state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rx_valid is a single-cycle strobe with no back-pressure: rx_data, parity_err and
  // frame_err are valid while it is high and hold their values until the next strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      par_bit_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_q == IDLE && state_d == DATA) begin
        cnt_q <= '0;
      end
      if (state_q == DATA && edge_ok) begin
        shift_q <= {d_bit, shift_q[DATA_BITS-1:1]};
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (state_q == PARITY && edge_ok) begin
        par_bit_q <= d_bit;
      end
      if (state_q == STOP && state_d == DONE) begin
        rx_data    <= shift_q;
        parity_err <= par_err_c;
        frame_err  <= ~d_bit;
        rx_valid   <= 1'b1;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic            rx_timeout_q;

  assign to_take = tx_idle && !fall_edge && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) &&
                   (state_q == DATA || state_q == PARITY || state_q == STOP);
  assign rx_timeout = rx_timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q     <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      rx_timeout_q <= to_take;
      if (state_q == IDLE || fall_edge) to_cnt_q <= '0;
      else                              to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign to_take    = 1'b0;
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: scoreboard of expected frames, bit-level PS/2 driver.
module tb_ps2_rx_frame;

  localparam int DATA_BITS      = 8;
  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ps2_c;
  logic                 ps2_d;
  logic                 tx_idle;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_timeout;
  logic                 busy;

  int checks     = 0;
  int failures   = 0;
  int rx_count   = 0;
  int sent_count = 0;
  int to_pulses  = 0;
  logic prev_valid = 1'b0;

  // {payload, parity_err, frame_err}
  logic [DATA_BITS+1:0] exp_q[$];
  logic [DATA_BITS+1:0] exp_e;

  ps2_rx_frame #(
    .DATA_BITS      (DATA_BITS),
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .ODD_PARITY     (1),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_c      (ps2_c),
    .ps2_d      (ps2_d),
    .tx_idle    (tx_idle),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_timeout (rx_timeout),
    .busy       (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling clk edge
  always @(negedge clk) begin
    if (rst) begin
      if (prev_valid) begin
        check("valid_width", {31'd0, rx_valid}, 32'd0);
        check("busy_after_valid", {31'd0, busy}, 32'd0);
      end
      if (rx_valid) begin
        rx_count++;
        check("busy_in_done", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(exp_e[DATA_BITS+1:2]));
          check("parity_err", {31'd0, parity_err}, {31'd0, exp_e[1]});
          check("frame_err", {31'd0, frame_err}, {31'd0, exp_e[0]});
        end
      end
      if (rx_timeout) to_pulses++;
      prev_valid = rx_valid;
    end
  end

  // driver tasks: inputs change 1 time unit after a rising clk edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_d = b;
    wait_cyc(10);
    ps2_c = 1'b0;
    wait_cyc(20);
    ps2_c = 1'b1;
    if (glitch) begin
      wait_cyc(8);
      ps2_c = 1'b0;
      wait_cyc(2);
      ps2_c = 1'b1;
      wait_cyc(8);
    end else begin
      wait_cyc(10);
    end
  endtask

  function automatic logic odd_par(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic par, input logic stop,
                            input int glitch_at);
    logic perr;
    perr = ((($countones(d) + int'(par)) % 2) == 0);
    exp_q.push_back({d, perr, ~stop});
    sent_count++;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < DATA_BITS; i++) ps2_bit(d[i], (i == glitch_at));
    ps2_bit(par, 1'b0);
    ps2_bit(stop, 1'b0);
    ps2_d = 1'b1;
    wait_cyc(20);
  endtask

  initial begin
    logic [DATA_BITS-1:0] v;
    int n;

    // reset
    rst     = 1'b0;
    ps2_c   = 1'b1;
    ps2_d   = 1'b1;
    tx_idle = 1'b1;
    #1;
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_rx_timeout", {31'd0, rx_timeout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(20);

    // good frame, parity error, recovered parity, stop error
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, -1);
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    send_frame(8'hAA, 1'b1, 1'b0, -1);
    check("count_after_basic", 32'(rx_count), 32'd4);

    // tx_idle low during the start bit: no frame starts
    tx_idle = 1'b0;
    ps2_bit(1'b0, 1'b0);
    check("busy_gated_start", {31'd0, busy}, 32'd0);
    ps2_d = 1'b1;
    wait_cyc(5);
    tx_idle = 1'b1;
    wait_cyc(10);

    // tx_idle dropped after 3 data bits: abort, data unchanged
    v = 8'h55;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(v[i], 1'b0);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    tx_idle = 1'b0;
    wait_cyc(1);
    check("busy_after_abort", {31'd0, busy}, 32'd0);
    wait_cyc(5);
    tx_idle = 1'b1;
    check("rx_data_hold", 32'(rx_data), 32'hAA);
    ps2_d = 1'b1;
    wait_cyc(10);
    send_frame(8'h55, odd_par(8'h55), 1'b1, -1);

    // short low glitch on ps2_c mid-frame
    send_frame(8'h3C, odd_par(8'h3C), 1'b1, 4);

    // random payloads with random parity/stop
    for (int k = 0; k < 3; k++) begin
      v = DATA_BITS'($urandom_range(0, (1 << DATA_BITS) - 1));
      send_frame(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    // ps2 clock stops after 4 data bits
    v = 8'h0F;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(v[i], 1'b0);
    ps2_d = v[3];
    wait_cyc(10);
    ps2_c = 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) ps2_c = 1'b1;
      if (rx_timeout) break;
    end
    // edge detection latency of the clock path, then TIMEOUT_CYCLES of silence
    check("timeout_latency", 32'(n), 32'(SYNC_STAGES + FILTER_LEN + 1 + TIMEOUT_CYCLES));
    check("busy_at_timeout", {31'd0, busy}, 32'd0);
    wait_cyc(1);
    check("timeout_width", {31'd0, rx_timeout}, 32'd0);
    ps2_c = 1'b1;
    ps2_d = 1'b1;
    wait_cyc(10);
`else
    n = 0;
    wait_cyc(20);
    ps2_c = 1'b1;
    ps2_d = 1'b1;
    wait_cyc(1200);
    check("busy_no_timeout", {31'd0, busy}, 32'd1);
    check("no_timeout_pulse", 32'(to_pulses), 32'd0);
    tx_idle = 1'b0;
    wait_cyc(3);
    tx_idle = 1'b1;
    check("busy_after_stall_abort", {31'd0, busy}, 32'd0);
    wait_cyc(10);
`endif
    send_frame(8'h12, odd_par(8'h12), 1'b1, -1);

    // final report
    wait_cyc(20);
`ifdef PS2_RX_TIMEOUT_EN
    check("timeout_pulses", 32'(to_pulses), 32'd1);
`else
    check("timeout_pulses", 32'(to_pulses), 32'd0);
`endif
    check("rx_count", 32'(rx_count), 32'(sent_count));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Parametrised PS/2 device-to-host frame receiver. It is the next generation of the split receive FSM plus external shift register and bit counter.
- Integrates clock/data synchronisers, a glitch filter, falling-edge detect, the shift register, the bit counter, and parity and stop checking.
- Delivers one word per frame with error flags.
- Sits between the PS/2 pins and the keyboard/mouse decoder. Yields the bus to the transmitter via tx_idle.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first; legal range 5..9.
- SYNC_STAGES, 2: flip-flop stages on ps2_c and ps2_d; minimum 2.
- FILTER_LEN, 4: consecutive equal synced ps2_c samples required before the filtered clock changes.
- ODD_PARITY, 1: 1 = odd parity, 0 = even parity.
- TIMEOUT_CYCLES, 100000: clk cycles without a falling edge before a partial frame is dropped (PS2_RX_TIMEOUT_EN only).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- ps2_c, in, 1: raw PS/2 clock pin.
- ps2_d, in, 1: raw PS/2 data pin.
- tx_idle, in, 1: 1 = transmitter not driving the bus; the receiver may start a frame.
- rx_data, out, DATA_BITS: last received payload.
- rx_valid, out, 1: one-cycle pulse; rx_data and the error flags are valid.
- parity_err, out, 1: parity mismatch on the frame flagged by rx_valid.
- frame_err, out, 1: stop bit sampled 0 on the frame flagged by rx_valid.
- rx_timeout, out, 1: one-cycle pulse; partial frame dropped.
- busy, out, 1: 1 while state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, shift register and bit count 0, synchroniser and filter flops 1. rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_timeout=0, busy=0.
- Input path: ps2_c and ps2_d each pass SYNC_STAGES flops. The filtered clock flips only after FILTER_LEN consecutive samples differ from its current value. fall_edge is a 1-cycle pulse when the filtered clock goes 1 to 0. Data is sampled from synced ps2_d in the fall_edge cycle.
- IDLE:
  - fall_edge with tx_idle=1 and data=0 -> DATA; bit count cleared.
  - fall_edge with data=1 is a spurious start; stay in IDLE.
  - tx_idle=0: all edges ignored.
- DATA: on each fall_edge, shift data in at the MSB and shift right, so the first bit lands in bit 0. Increment the count. The fall_edge that makes count equal DATA_BITS moves to PARITY.
- PARITY: on fall_edge, latch the parity bit and move to STOP.
  - Odd mode: error if the ones count over payload+parity is even.
  - Even mode: error if that count is odd.
- STOP: on fall_edge, latch the stop bit and move to DONE.
- DONE: one cycle, then IDLE.
  - Registered outputs update on the DONE entry edge: rx_data loads the shift register, parity_err and frame_err load their computed values, rx_valid=1.
  - So rx_valid is high in the cycle after the stop-bit fall_edge, for exactly one cycle.
  - rx_data and the error flags hold until the next rx_valid.
- Abort: tx_idle=0 in DATA, PARITY or STOP -> IDLE next cycle. No rx_valid, no rx_timeout, rx_data unchanged.
- Simultaneous fall_edge and tx_idle fall: the abort wins.
- Back-to-back frames: a start edge arriving in the DONE cycle is ignored. PS/2 timing guarantees at least 30 us between frames.
- Undefined state encodings -> IDLE.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter of ceil(log2(TIMEOUT_CYCLES)) bits clears on every fall_edge and in IDLE, and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE next cycle, rx_timeout pulses 1 cycle, no rx_valid.
  - Abort has priority over timeout.
- Not defined: no counter; rx_timeout is tied 0; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum IDLE/DATA/PARITY/STOP/DONE;
  - PAR_ODD/PAR_EVEN constants;
  - frame-length helper constant START+DATA_BITS+PARITY+STOP.
- One natural sub-module, ps2_sync_filter: synchroniser, glitch filter and fall_edge generation, parametrised by SYNC_STAGES and FILTER_LEN. Instantiate it once for the clock; the data line uses synchroniser stages only.

Test Plan:
- Good frame, defaults: start 0, payload 0x1C LSB first (0,0,1,1,1,0,0,0), parity 0, stop 1 -> one rx_valid pulse the cycle after the stop edge; rx_data=0x1C, parity_err=0, frame_err=0, busy falls with it.
- Parity error: 0x1C sent with parity 1 -> rx_data=0x1C, parity_err=1, frame_err=0. Then 0xF0 sent with parity 1 -> parity_err=0.
- Stop error: 0xAA sent with correct parity 1 and stop 0 -> rx_data=0xAA, frame_err=1, parity_err=0.
- tx_idle gating: tx_idle=0 during start bit -> busy stays 0, no rx_valid. tx_idle dropped after 3 data bits -> IDLE next cycle, no pulses. A following 0x55 frame is received correctly.
- Glitch: a ps2_c low pulse shorter than FILTER_LEN clk cycles mid-frame -> bit count unchanged; frame 0x3C still received correct.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=1000: stop the clock after 4 data bits -> rx_timeout pulses exactly 1000 cycles after the last edge, busy=0. Next frame 0x12 is received correctly. Without the macro, rx_timeout stays 0 and busy stays 1.
